logic_reduce: RTL and testbench

LOGIC_REDUCE -- requirements
Module: logic_reduce

---
 rtl/logic_reduce_if.sv | 24 ++
 rtl/logic_reduce.sv | 105 ++++++++++
 tb/tb_logic_reduce.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/logic_reduce_if.sv
// Handshake bundle for logic_reduce: the operand/opcode input side and the
// single-bit result output side. The slave modport is the reducer's view;
// master is the producer/consumer driving it.
interface logic_reduce_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic             out_data;

  modport master (
    output in_valid, din, op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, din, op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/logic_reduce.sv
// logic_reduce: two-stage valid/ready pipeline reducing a WIDTH-bit operand
// to one bit using OR, AND, XOR (parity) or majority.
// Stage 1 holds the accepted operand and opcode; stage 2 holds the result.
// Both stages move together whenever the output slot is empty or being
// drained, so in_ready is that same advance condition.
// Optional feature macro: LOGIC_REDUCE_CNT_EN enables the saturating count of
// accepted results equal to 1 (hit_cnt, cleared by cnt_clr). Without it,
// hit_cnt is tied to 0, cnt_clr is ignored and no counter register exists.
module logic_reduce #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_reduce_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_MAJ = 2'b11
  } op_e;

  // Wide enough that 2*popcount never overflows for any legal WIDTH.
  localparam int PW = $clog2(WIDTH + 1) + 1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_din;
  op_e              s1_op;
  logic             out_valid_q;
  logic             out_data_q;
  logic             adv;
  logic             result;
  logic [PW-1:0]    pop;

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Reduce the stage 1 operand according to its opcode.
  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop    = '0;
    result = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(s1_din[i]);
    end
    case (s1_op)
      OP_OR:   result = |s1_din;
      OP_AND:  result = &s1_din;
      OP_XOR:  result = ^s1_din;
      OP_MAJ:  result = (pop << 1) > PW'(WIDTH);
      default: result = 1'b0;
    endcase
  end

  // Pipeline registers: both stages advance together or both hold.
  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values, letting stage 2 take stage 1's old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_din      <= '0;
      s1_op       <= OP_OR;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
    end else if (adv) begin
      s1_valid    <= bus.in_valid;
      s1_din      <= bus.din;
      s1_op       <= op_e'(bus.op);
      out_valid_q <= s1_valid;
      out_data_q  <= result;
    end
  end

`ifdef LOGIC_REDUCE_CNT_EN
  logic [CNT_W-1:0] hit_q;
  logic             out_hs;

  assign out_hs  = out_valid_q && bus.out_ready;
  assign hit_cnt = hit_q;

  // Saturating count of delivered 1-results; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else if (cnt_clr) begin
      hit_q <= '0;
    end else if (out_hs && out_data_q && (hit_q != '1)) begin
      hit_q <= hit_q + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_logic_reduce.sv
// Directed self-checking bench for logic_reduce. A WIDTH=3/CNT_W=4 instance
// covers the handshake, stall, counter and reset behaviour; a WIDTH=4
// instance covers parity and the even-width majority tie. Inputs change and
// outputs are sampled just after the falling edge.
module tb_logic_reduce;

`ifdef LOGIC_REDUCE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [1:0] OR_ = 2'b00;
  localparam logic [1:0] AND_ = 2'b01;
  localparam logic [1:0] XOR_ = 2'b10;
  localparam logic [1:0] MAJ_ = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr3;
  logic        clr4;
  logic [3:0]  hit3;
  logic [15:0] hit4;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;

  logic_reduce_if #(.WIDTH(3)) bus3 ();
  logic_reduce_if #(.WIDTH(4)) bus4 ();

  logic_reduce #(.WIDTH(3), .CNT_W(4)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus3),
    .cnt_clr (clr3),
    .hit_cnt (hit3)
  );

  logic_reduce #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus4),
    .cnt_clr (clr4),
    .hit_cnt (hit4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv3(input bit v, input logic [2:0] d, input logic [1:0] o,
                      input bit ordy, input bit clr);
    bus3.in_valid  = v;
    bus3.din       = d;
    bus3.op        = o;
    bus3.out_ready = ordy;
    clr3           = clr;
    #1;
  endtask

  task automatic drv4(input bit v, input logic [3:0] d, input logic [1:0] o);
    bus4.in_valid  = v;
    bus4.din       = d;
    bus4.op        = o;
    bus4.out_ready = 1'b1;
    #1;
  endtask

  // Compare dut3 against expectations, then advance the hit model by what
  // the coming rising edge should do.
  task automatic chk3(input string tag, input bit ev, input bit ed, input bit erdy);
    check({tag, ".in_ready"}, 32'(bus3.in_ready), 32'(erdy));
    check({tag, ".out_valid"}, 32'(bus3.out_valid), 32'(ev));
    if (ev) check({tag, ".out_data"}, 32'(bus3.out_data), 32'(ed));
    check({tag, ".hit_cnt"}, 32'(hit3), CNT_EN ? exp_hits : 0);
    if (clr3) exp_hits = 0;
    else if (ev && bus3.out_ready && ed && exp_hits < 15) exp_hits++;
  endtask

  task automatic chk4(input string tag, input bit ev, input bit ed);
    check({tag, ".out_valid"}, 32'(bus4.out_valid), 32'(ev));
    if (ev) check({tag, ".out_data"}, 32'(bus4.out_data), 32'(ed));
  endtask

  initial begin
    bus3.in_valid = 1'b0; bus3.din = '0; bus3.op = OR_; bus3.out_ready = 1'b1; clr3 = 1'b0;
    bus4.in_valid = 1'b0; bus4.din = '0; bus4.op = OR_; bus4.out_ready = 1'b1; clr4 = 1'b0;

    // Reset state
    #1;
    chk3("rst", 1'b0, 1'b0, 1'b1);
    check("rst.out_data", 32'(bus3.out_data), 0);
    check("rst.hit4", 32'(hit4), 0);
    chk4("rst4", 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk3("rel", 1'b0, 1'b0, 1'b1);

    // Basic OR/AND stream, 2-cycle latency
    tick(); drv3(1, 3'b000, OR_,  1, 0); chk3("b0", 0, 0, 1);
    tick(); drv3(1, 3'b100, OR_,  1, 0); chk3("b1", 0, 0, 1);
    tick(); drv3(1, 3'b111, AND_, 1, 0); chk3("b2", 1, 0, 1);
    tick(); drv3(1, 3'b110, AND_, 1, 0); chk3("b3", 1, 1, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("b4", 1, 1, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("b5", 1, 0, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("b6", 0, 0, 1);

    // Majority and parity at WIDTH=3
    tick(); drv3(1, 3'b011, MAJ_, 1, 0); chk3("m0", 0, 0, 1);
    tick(); drv3(1, 3'b001, MAJ_, 1, 0); chk3("m1", 0, 0, 1);
    tick(); drv3(1, 3'b111, XOR_, 1, 0); chk3("m2", 1, 1, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("m3", 1, 0, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("m4", 1, 1, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("m5", 0, 0, 1);

    // WIDTH=4: parity and even-width majority tie
    tick(); drv4(1, 4'b1011, XOR_); chk4("w0", 0, 0);
    tick(); drv4(1, 4'b1100, MAJ_); chk4("w1", 0, 0);
    tick(); drv4(1, 4'b1101, MAJ_); chk4("w2", 1, 1);
    tick(); drv4(0, 4'b0000, OR_);  chk4("w3", 1, 0);
    tick(); drv4(0, 4'b0000, OR_);  chk4("w4", 1, 1);
    tick(); drv4(0, 4'b0000, OR_);  chk4("w5", 0, 0);

    // Five back-to-back inputs with a 3-cycle output stall: results 0,1,0,1,0
    tick(); drv3(1, 3'b101, XOR_, 1, 0); chk3("s0", 0, 0, 1);
    tick(); drv3(1, 3'b001, OR_,  1, 0); chk3("s1", 0, 0, 1);
    tick(); drv3(1, 3'b100, MAJ_, 1, 0); chk3("s2", 1, 0, 1);
    tick(); drv3(1, 3'b111, AND_, 0, 0); chk3("s3", 1, 1, 0);
    tick(); drv3(1, 3'b111, AND_, 0, 0); chk3("s4", 1, 1, 0);
    tick(); drv3(1, 3'b111, AND_, 0, 0); chk3("s5", 1, 1, 0);
    tick(); drv3(1, 3'b111, AND_, 1, 0); chk3("s6", 1, 1, 1);
    tick(); drv3(1, 3'b011, XOR_, 1, 0); chk3("s7", 1, 0, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("s8", 1, 1, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("s9", 1, 0, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("s10", 0, 0, 1);

    // Counter: clear, then 20 results of 1 to reach saturation
    tick(); drv3(0, 3'b000, OR_, 1, 1); chk3("c_clr", 0, 0, 1);
    for (int i = 0; i < 23; i++) begin
      tick();
      drv3(i < 20, 3'b111, OR_, 1, 0);
      chk3($sformatf("sat%0d", i), (i >= 2) && (i < 22), 1'b1, 1'b1);
    end
    check("sat.final", 32'(hit3), CNT_EN ? 15 : 0);

    // Clear coinciding with a handshake of result 1: clear wins
    tick(); drv3(1, 3'b111, OR_, 1, 0); chk3("cc0", 0, 0, 1);
    tick(); drv3(0, 3'b000, OR_, 1, 0); chk3("cc1", 0, 0, 1);
    tick(); drv3(0, 3'b000, OR_, 1, 1); chk3("cc2", 1, 1, 1);
    tick(); drv3(0, 3'b000, OR_, 1, 0); chk3("cc3", 0, 0, 1);
    check("clr.final", 32'(hit3), 0);
    tick(); drv3(1, 3'b010, OR_, 1, 0); chk3("inc0", 0, 0, 1);
    tick(); drv3(0, 3'b000, OR_, 1, 0); chk3("inc1", 0, 0, 1);
    tick(); drv3(0, 3'b000, OR_, 1, 0); chk3("inc2", 1, 1, 1);
    tick(); drv3(0, 3'b000, OR_, 1, 0); chk3("inc3", 0, 0, 1);

    // Asynchronous reset with two results in flight
    tick(); drv3(1, 3'b111, OR_, 1, 0); chk3("r0", 0, 0, 1);
    tick(); drv3(1, 3'b001, OR_, 1, 0); chk3("r1", 0, 0, 1);
    tick(); drv3(0, 3'b000, OR_, 0, 0); chk3("r2", 1, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    exp_hits = 0;
    chk3("r_async", 0, 0, 1);
    check("r_async.out_data", 32'(bus3.out_data), 0);
    tick(); drv3(0, 3'b000, OR_, 1, 0); chk3("r_hold", 0, 0, 1);
    rst_n = 1'b1;
    #1;
    chk3("r_rel", 0, 0, 1);
    tick(); drv3(0, 3'b000, OR_, 1, 0); chk3("r_idle0", 0, 0, 1);
    tick(); drv3(0, 3'b000, OR_, 1, 0); chk3("r_idle1", 0, 0, 1);
    tick(); drv3(1, 3'b110, XOR_, 1, 0); chk3("r_idle2", 0, 0, 1);
    tick(); drv3(1, 3'b011, OR_,  1, 0); chk3("r_new0", 0, 0, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("r_new1", 1, 0, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("r_new2", 1, 1, 1);
    tick(); drv3(0, 3'b000, OR_,  1, 0); chk3("r_new3", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
